cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port CLK, input, 1, beat clock; all state updates on rising edge.
REQ-002 SHALL have port CLR, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port QD, input, 1, start pushbutton; level, synchronous to CLK.
REQ-004 SHALL have control input ports LDZ, LDC, CIN, DRW, M, ABUS, SBUS, MBUS, PCINC, PCADD, ARINC, LPC, LAR, LIR, MEMW, STOP, SELCTL, LONG, SHORT, each 1 bit; S, SEL, each 4 bits.
REQ-005 SHALL have port SD, input, 8, switch data.
REQ-006 SHALL have port MEM_RDATA, input, 8, combinational memory read data.
REQ-007 SHALL have port W1/W2/W3, output, 1 each, one-hot beat state.
REQ-008 SHALL have port RUN, output, 1, sequencer running.
REQ-009 SHALL have port IR, output, 4, opcode = IREG[7:4].
REQ-010 SHALL have port C / Z, output, 1 each, flag registers.
REQ-011 SHALL have port MEM_ADDR, output, 8; MEM_WDATA, output, 8; MEM_WE, output, 1.
REQ-012 SHALL have port PC / AR / DBUS, output, 8 each, debug view.

Function
REQ-013 Beat FSM, states W1,W2,W3. Advances only when RUN=1: W1->W1 if SHORT, else W2; W2->W3 if LONG, else W1; W3->W1.
REQ-014 RUN SHALL set on the rising edge of a synchronized QD (0->1 detected across two samples) and clear at the end of any beat with STOP=1 while RUN=1. STOP wins over a simultaneous QD edge. While RUN=0, the beat state holds.
REQ-015 All register/memory writes SHALL be gated by RUN=1. Writes commit at the CLK edge that ends the beat.
REQ-016 IREG is 8 bits. Register fields: RD=IREG[3:2], RS=IREG[1:0].
REQ-017 Register file: R0-R3, 8 bits each.
  - SELCTL=0: A-port=R[RD], B-port=R[RS], write address=RD.
  - SELCTL=1: A-port=R[SEL[3:2]], B-port=R[SEL[1:0]], write address=SEL[3:2].
  - DRW=1 writes DBUS.
REQ-018 ALU, cin=~CIN (CIN active-low), result 9 bits, C_out=bit8.
  - M=0,S=1001: A+B+cin.
  - M=0,S=0110: A+~B+cin.
  - M=0,S=0000: A+cin.
  - M=1,S=1011: A&B.
  - M=1,S=1110: A|B.
  - M=1,S=0110: A^B.
  - M=1,S=1111: A.
  - M=1,S=1010: B.
  - Any other code: 0x00, C_out=0.
REQ-019 DBUS priority: ABUS (ALU[7:0]) > MBUS (MEM_RDATA) > SBUS (SD). No driver selected gives 0x00.
REQ-020 Flags: LDC loads C<=C_out. LDZ loads Z<=(ALU[7:0]==0). Otherwise the flags hold.
REQ-021 PC update priority: LPC (PC<=DBUS) > PCADD (PC<=PC+sign-extended IREG[3:0]) > PCINC (PC<=PC+1). All PC arithmetic is mod 256.
REQ-022 AR update priority: LAR (AR<=DBUS) > ARINC (AR<=AR+1, wraps 0xFF->0x00).
REQ-023 LIR SHALL load IREG<=MEM_RDATA.
REQ-024 MEM_ADDR SHALL be PC when LIR=1, else AR.
REQ-025 MEM_WDATA SHALL be DBUS.
REQ-026 MEM_WE SHALL be MEMW & RUN.
REQ-027 LIR, PCINC and DRW asserted together in the same beat SHALL all take effect. Each update uses values from before the edge.

Reset
REQ-028 CLR=0 SHALL immediately force the following, regardless of CLK, including mid-beat: beat=W1, RUN=0, PC=AR=IREG=0x00, R0-R3=0x00, C=Z=0, QD synchronizer=0.
REQ-029 After CLR releases, the block SHALL stay idle until a QD edge.

Verification
REQ-030 Reset mid-W2 with RUN=1 -> W1=1, RUN=0, PC=0x00 within the same cycle; no write on the next edge.
REQ-031 RUN=1, LONG=0, SHORT=0 -> beat sequence W1,W2,W1. With LONG=1 at W2 -> W1,W2,W3,W1. With SHORT=1 at W1 -> W1 is held.
REQ-032 R1=0xFF, R2=0x01, SELCTL=0, IREG=0x16, W2: M=0, S=1001, CIN=1, ABUS, DRW, LDC, LDZ -> R1=0x00, C=1, Z=1.
REQ-033 PC=0x10, IREG=0x7E, PCADD=1 -> PC=0x0E. PC=0xFF, PCINC=1 -> PC=0x00.
REQ-034 AR=0x20, MEMW=1, ABUS, M=1, S=1010, B-port=0x5A -> MEM_WE=1, MEM_ADDR=0x20, MEM_WDATA=0x5A. With RUN=0 -> MEM_WE=0.
REQ-035 STOP=1 and a QD edge in the same beat -> RUN=0. A later QD edge -> RUN=1, and the beat resumes from the held state.

Source files
------------

// File: rtl/cpu_datapath.sv
// cpu_datapath: beat-sequenced 8-bit datapath with W1/W2/W3 beat FSM, 4x8 register file,
// ALU with C/Z flags, PC/AR/IREG and a combinational external memory port.
module cpu_datapath (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       LDZ,
    input  logic       LDC,
    input  logic       CIN,
    input  logic       DRW,
    input  logic       M,
    input  logic       ABUS,
    input  logic       SBUS,
    input  logic       MBUS,
    input  logic       PCINC,
    input  logic       PCADD,
    input  logic       ARINC,
    input  logic       LPC,
    input  logic       LAR,
    input  logic       LIR,
    input  logic       MEMW,
    input  logic       STOP,
    input  logic       SELCTL,
    input  logic       LONG,
    input  logic       SHORT,
    input  logic [3:0] S,
    input  logic [3:0] SEL,
    input  logic [7:0] SD,
    input  logic [7:0] MEM_RDATA,
    output logic       W1,
    output logic       W2,
    output logic       W3,
    output logic       RUN,
    output logic [3:0] IR,
    output logic       C,
    output logic       Z,
    output logic [7:0] MEM_ADDR,
    output logic [7:0] MEM_WDATA,
    output logic       MEM_WE,
    output logic [7:0] PC,
    output logic [7:0] AR,
    output logic [7:0] DBUS
);
    typedef enum logic [1:0] {beat_w1 = 2'd0, beat_w2 = 2'd1, beat_w3 = 2'd2} beat_t;
    beat_t beat, beat_n;
    logic run, qd_s0, qd_s1, qd_edge;
    logic [7:0] pc, ar, ireg, pc_n, ar_n, a_val, b_val, dbus;
    logic [7:0] regs [4];
    logic [1:0] ra, rb;
    logic [8:0] alu;
    logic c, z, cin;
    // beat state register; holds while the sequencer is stopped
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) beat <= beat_w1;
        else beat <= beat_n;
    end
    always_comb begin
        beat_n = !run ? beat :
                 beat == beat_w1 ? (SHORT ? beat_w1 : beat_w2) :
                 beat == beat_w2 ? (LONG ? beat_w3 : beat_w1) : beat_w1;
    end
    always_comb begin
        W1 = beat == beat_w1;
        W2 = beat == beat_w2;
        W3 = beat == beat_w3;
    end
    // QD is sampled twice so a press is seen as a single 0->1 edge; STOP beats a same-beat edge
    assign qd_edge = qd_s0 & ~qd_s1;
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            qd_s0 <= 1'b0;
            qd_s1 <= 1'b0;
            run   <= 1'b0;
        end else begin
            qd_s0 <= QD;
            qd_s1 <= qd_s0;
            run   <= ~STOP & (run | qd_edge);
        end
    end
    assign ra    = SELCTL ? SEL[3:2] : ireg[3:2];
    assign rb    = SELCTL ? SEL[1:0] : ireg[1:0];
    assign a_val = regs[ra];
    assign b_val = regs[rb];
    assign cin   = ~CIN;
    always_comb begin
        alu = 9'd0;
        case ({M, S})
            5'b0_1001: alu = {1'b0, a_val} + {1'b0, b_val} + {8'd0, cin};
            5'b0_0110: alu = {1'b0, a_val} + {1'b0, ~b_val} + {8'd0, cin};
            5'b0_0000: alu = {1'b0, a_val} + {8'd0, cin};
            5'b1_1011: alu = {1'b0, a_val & b_val};
            5'b1_1110: alu = {1'b0, a_val | b_val};
            5'b1_0110: alu = {1'b0, a_val ^ b_val};
            5'b1_1111: alu = {1'b0, a_val};
            5'b1_1010: alu = {1'b0, b_val};
            default:   alu = 9'd0;
        endcase
    end
    always_comb begin
        dbus = ABUS ? alu[7:0] : MBUS ? MEM_RDATA : SBUS ? SD : 8'h00;
        pc_n = LPC ? dbus : PCADD ? pc + {{4{ireg[3]}}, ireg[3:0]} : PCINC ? pc + 8'd1 : pc;
        ar_n = LAR ? dbus : ARINC ? ar + 8'd1 : ar;
    end
    // every architectural write happens only while running, at the edge closing the beat
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pc   <= 8'h00;
            ar   <= 8'h00;
            ireg <= 8'h00;
            c    <= 1'b0;
            z    <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (run) begin
            if (DRW) regs[ra] <= dbus;
            if (LDC) c <= alu[8];
            if (LDZ) z <= alu[7:0] == 8'h00;
            if (LIR) ireg <= MEM_RDATA;
            pc <= pc_n;
            ar <= ar_n;
        end
    end
    assign RUN       = run;
    assign IR        = ireg[7:4];
    assign C         = c;
    assign Z         = z;
    assign PC        = pc;
    assign AR        = ar;
    assign DBUS      = dbus;
    assign MEM_ADDR  = LIR ? pc : ar;
    assign MEM_WDATA = dbus;
    assign MEM_WE    = MEMW & run;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed scenario tasks plus a randomized run, all checked against
// a behavioural model of the datapath held in the bench.
module tb_cpu_datapath;
    logic CLK = 1'b0, CLR = 1'b0, QD = 1'b0;
    logic LDZ, LDC, CIN, DRW, M, ABUS, SBUS, MBUS, PCINC, PCADD, ARINC;
    logic LPC, LAR, LIR, MEMW, STOP, SELCTL, LONG, SHORT;
    logic [3:0] S, SEL;
    logic [7:0] SD, MEM_RDATA;
    logic W1, W2, W3, RUN, C, Z, MEM_WE;
    logic [3:0] IR;
    logic [7:0] MEM_ADDR, MEM_WDATA, PC, AR, DBUS;
    int tests = 0, fails = 0;

    logic [7:0] m_r [4];
    logic [7:0] m_pc, m_ar, m_ir;
    logic m_c, m_z, m_run, m_qd_last, m_qd_prev;
    int m_beat;

    cpu_datapath dut (
        .CLK(CLK), .CLR(CLR), .QD(QD), .LDZ(LDZ), .LDC(LDC), .CIN(CIN), .DRW(DRW), .M(M),
        .ABUS(ABUS), .SBUS(SBUS), .MBUS(MBUS), .PCINC(PCINC), .PCADD(PCADD), .ARINC(ARINC),
        .LPC(LPC), .LAR(LAR), .LIR(LIR), .MEMW(MEMW), .STOP(STOP), .SELCTL(SELCTL),
        .LONG(LONG), .SHORT(SHORT), .S(S), .SEL(SEL), .SD(SD), .MEM_RDATA(MEM_RDATA),
        .W1(W1), .W2(W2), .W3(W3), .RUN(RUN), .IR(IR), .C(C), .Z(Z), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .PC(PC), .AR(AR), .DBUS(DBUS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_aval();
        return m_r[SELCTL ? SEL[3:2] : m_ir[3:2]];
    endfunction
    function automatic logic [7:0] m_bval();
        return m_r[SELCTL ? SEL[1:0] : m_ir[1:0]];
    endfunction
    function automatic logic [8:0] m_alu();
        int a = m_aval();
        int b = m_bval();
        int ci = CIN ? 0 : 1;
        int r = 0;
        if (!M && S == 4'd9) r = a + b + ci;
        else if (!M && S == 4'd6) r = a + (255 - b) + ci;
        else if (!M && S == 4'd0) r = a + ci;
        else if (M && S == 4'd11) r = a & b;
        else if (M && S == 4'd14) r = a | b;
        else if (M && S == 4'd6) r = a ^ b;
        else if (M && S == 4'd15) r = a;
        else if (M && S == 4'd10) r = b;
        return 9'(r);
    endfunction
    function automatic logic [7:0] m_dbus();
        logic [8:0] al = m_alu();
        return ABUS ? al[7:0] : MBUS ? MEM_RDATA : SBUS ? SD : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 0; m_ar = 0; m_ir = 0; m_c = 0; m_z = 0; m_run = 0;
        m_qd_last = 0; m_qd_prev = 0; m_beat = 1;
    endtask

    task automatic idle_ctl();
        {LDZ, LDC, CIN, DRW, M, ABUS, SBUS, MBUS, PCINC, PCADD, ARINC} = '0;
        {LPC, LAR, LIR, MEMW, STOP, SELCTL, LONG, SHORT} = '0;
        S = 4'h0; SEL = 4'h0; SD = 8'h00; MEM_RDATA = 8'h00;
    endtask

    // one beat: compute the model's next state from pre-edge values, then commit after the edge
    task automatic tick();
        logic [8:0] al = m_alu();
        logic [7:0] db = m_dbus();
        logic [1:0] wa = SELCTL ? SEL[3:2] : m_ir[3:2];
        logic press = m_qd_last && !m_qd_prev;
        logic [7:0] n_pc = m_pc, n_ar = m_ar, n_ir = m_ir;
        logic n_c = m_c, n_z = m_z;
        int n_beat = m_beat;
        logic n_run = !STOP && (m_run || press);
        logic do_wr = 0;
        if (m_run) begin
            n_beat = (m_beat == 1) ? (SHORT ? 1 : 2) : (m_beat == 2) ? (LONG ? 3 : 1) : 1;
            do_wr = DRW;
            if (LDC) n_c = al[8];
            if (LDZ) n_z = (al[7:0] == 0);
            if (LPC) n_pc = db;
            else if (PCADD) n_pc = 8'(int'(m_pc) + (m_ir[3] ? int'(m_ir[3:0]) - 16 : int'(m_ir[3:0])));
            else if (PCINC) n_pc = 8'(int'(m_pc) + 1);
            if (LAR) n_ar = db;
            else if (ARINC) n_ar = 8'(int'(m_ar) + 1);
            if (LIR) n_ir = MEM_RDATA;
        end
        m_qd_prev = m_qd_last;
        m_qd_last = QD;
        @(posedge CLK);
        #1;
        if (do_wr) m_r[wa] = db;
        m_pc = n_pc; m_ar = n_ar; m_ir = n_ir; m_c = n_c; m_z = n_z;
        m_run = n_run; m_beat = n_beat;
    endtask

    task automatic start_run();
        idle_ctl();
        QD = 1'b0;
        repeat (2) tick();
        QD = 1'b1;
        repeat (3) tick();
        QD = 1'b0;
        tests++;
        if (RUN !== 1'b1) begin
            fails++;
            $display("FAIL run_after_qd: got %b want 1", RUN);
        end
    endtask

    task automatic wr_reg(input logic [1:0] n, input logic [7:0] v);
        idle_ctl();
        SELCTL = 1; SEL = {n, 2'b00}; SBUS = 1; SD = v; DRW = 1;
        tick();
        idle_ctl();
    endtask

    task automatic test_reset();
        tests++;
        if ({W1, W2, W3, RUN, PC, AR, IR, C, Z} !== {3'b100, 1'b0, 8'h00, 8'h00, 4'h0, 2'b00}) begin
            fails++;
            $display("FAIL reset_state: got %b%b%b run=%b pc=%h ar=%h ir=%h c=%b z=%b want 100 run=0 zeros",
                     W1, W2, W3, RUN, PC, AR, IR, C, Z);
        end
        repeat (4) tick();
        tests++;
        if (RUN !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got run=%b want 0", RUN);
        end
        start_run();
        idle_ctl();
        SBUS = 1; SD = 8'h33; LPC = 1; LAR = 1;
        tick();
        idle_ctl();
        for (int i = 0; i < 4 && m_beat != 2; i++) tick();
        tests++;
        if (W2 !== 1'b1 || PC !== 8'h33) begin
            fails++;
            $display("FAIL pre_reset_w2: got w2=%b pc=%h want w2=1 pc=33", W2, PC);
        end
        #2 CLR = 1'b0;
        #1;
        tests++;
        if ({W1, W2, W3, RUN, PC, AR} !== {3'b100, 1'b0, 8'h00, 8'h00}) begin
            fails++;
            $display("FAIL async_reset: got %b%b%b run=%b pc=%h ar=%h want 100 run=0 pc=00 ar=00",
                     W1, W2, W3, RUN, PC, AR);
        end
        model_reset();
        SELCTL = 1; SEL = 4'b0000; SBUS = 1; SD = 8'h77; DRW = 1; LPC = 1;
        @(negedge CLK);
        CLR = 1'b1;
        tick();
        idle_ctl();
        SELCTL = 1; SEL = 4'b0000; ABUS = 1; M = 1; S = 4'b1111;
        #1;
        tests++;
        if (DBUS !== 8'h00 || PC !== 8'h00) begin
            fails++;
            $display("FAIL no_write_after_reset: got r0=%h pc=%h want 00 00", DBUS, PC);
        end
        idle_ctl();
    endtask

    task automatic test_beats();
        start_run();
        for (int i = 0; i < 4 && m_beat != 1; i++) tick();
        tests++;
        if ({W1, W2, W3} !== 3'b100) begin
            fails++;
            $display("FAIL beat_align: got %b%b%b want 100", W1, W2, W3);
        end
        tick();
        tests++;
        if ({W1, W2, W3} !== 3'b010) begin
            fails++;
            $display("FAIL beat_w1_w2: got %b%b%b want 010", W1, W2, W3);
        end
        tick();
        tests++;
        if ({W1, W2, W3} !== 3'b100) begin
            fails++;
            $display("FAIL beat_w2_w1: got %b%b%b want 100", W1, W2, W3);
        end
        LONG = 1;
        tick();
        tick();
        tests++;
        if ({W1, W2, W3} !== 3'b001) begin
            fails++;
            $display("FAIL beat_long_w3: got %b%b%b want 001", W1, W2, W3);
        end
        tick();
        tests++;
        if ({W1, W2, W3} !== 3'b100) begin
            fails++;
            $display("FAIL beat_w3_w1: got %b%b%b want 100", W1, W2, W3);
        end
        LONG = 0; SHORT = 1;
        repeat (2) tick();
        tests++;
        if ({W1, W2, W3} !== 3'b100) begin
            fails++;
            $display("FAIL beat_short_hold: got %b%b%b want 100", W1, W2, W3);
        end
        idle_ctl();
    endtask

    task automatic test_alu_flags();
        wr_reg(2'd1, 8'hFF);
        wr_reg(2'd2, 8'h01);
        LIR = 1; MEM_RDATA = 8'h16;
        tick();
        idle_ctl();
        tests++;
        if (IR !== 4'h1) begin
            fails++;
            $display("FAIL ir_load: got %h want 1", IR);
        end
        M = 0; S = 4'b1001; CIN = 1; ABUS = 1; DRW = 1; LDC = 1; LDZ = 1;
        #1;
        tests++;
        if (DBUS !== 8'h00) begin
            fails++;
            $display("FAIL add_dbus: got %h want 00", DBUS);
        end
        tick();
        idle_ctl();
        tests++;
        if (C !== 1'b1 || Z !== 1'b1) begin
            fails++;
            $display("FAIL add_flags: got c=%b z=%b want c=1 z=1", C, Z);
        end
        SELCTL = 1; SEL = 4'b0100; ABUS = 1; M = 1; S = 4'b1111;
        #1;
        tests++;
        if (DBUS !== 8'h00) begin
            fails++;
            $display("FAIL add_r1: got %h want 00", DBUS);
        end
        idle_ctl();
        SELCTL = 1; SEL = 4'b0110; M = 0; S = 4'b0110; CIN = 0; ABUS = 1; LDC = 1; LDZ = 1;
        #1;
        tests++;
        if (DBUS !== 8'hFF) begin
            fails++;
            $display("FAIL sub_dbus: got %h want ff", DBUS);
        end
        tick();
        idle_ctl();
        tests++;
        if (C !== 1'b0 || Z !== 1'b0) begin
            fails++;
            $display("FAIL sub_flags: got c=%b z=%b want c=0 z=0", C, Z);
        end
    endtask

    task automatic test_pc();
        SBUS = 1; SD = 8'h10; LPC = 1;
        tick();
        idle_ctl();
        LIR = 1; MEM_RDATA = 8'h7E;
        tick();
        idle_ctl();
        PCADD = 1;
        tick();
        idle_ctl();
        tests++;
        if (PC !== 8'h0E) begin
            fails++;
            $display("FAIL pc_add_neg: got %h want 0e", PC);
        end
        SBUS = 1; SD = 8'hFF; LPC = 1;
        tick();
        idle_ctl();
        PCINC = 1;
        tick();
        idle_ctl();
        tests++;
        if (PC !== 8'h00) begin
            fails++;
            $display("FAIL pc_inc_wrap: got %h want 00", PC);
        end
        SBUS = 1; SD = 8'h40; LPC = 1; PCINC = 1; PCADD = 1;
        tick();
        idle_ctl();
        tests++;
        if (PC !== 8'h40) begin
            fails++;
            $display("FAIL pc_priority: got %h want 40", PC);
        end
    endtask

    task automatic test_mem();
        SBUS = 1; SD = 8'h20; LAR = 1;
        tick();
        wr_reg(2'd3, 8'h5A);
        SELCTL = 1; SEL = 4'b0011; ABUS = 1; M = 1; S = 4'b1010; MEMW = 1;
        #1;
        tests++;
        if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 8'h20, 8'h5A}) begin
            fails++;
            $display("FAIL mem_write: got we=%b addr=%h wdata=%h want we=1 addr=20 wdata=5a",
                     MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        LIR = 1;
        #1;
        tests++;
        if (MEM_ADDR !== PC) begin
            fails++;
            $display("FAIL mem_addr_lir: got %h want %h", MEM_ADDR, m_pc);
        end
        idle_ctl();
        SBUS = 1; SD = 8'hFF; LAR = 1;
        tick();
        idle_ctl();
        ARINC = 1;
        tick();
        idle_ctl();
        tests++;
        if (AR !== 8'h00) begin
            fails++;
            $display("FAIL ar_inc_wrap: got %h want 00", AR);
        end
    endtask

    task automatic test_stop_qd();
        logic [2:0] held;
        idle_ctl();
        QD = 0;
        repeat (2) tick();
        QD = 1;
        tick();
        STOP = 1;
        tick();
        STOP = 0;
        held = {W1, W2, W3};
        tests++;
        if (RUN !== 1'b0) begin
            fails++;
            $display("FAIL stop_beats_qd: got run=%b want 0", RUN);
        end
        MEMW = 1;
        #1;
        tests++;
        if (MEM_WE !== 1'b0) begin
            fails++;
            $display("FAIL mem_we_stopped: got %b want 0", MEM_WE);
        end
        MEMW = 0; DRW = 1; SBUS = 1; SD = 8'hC3; LPC = 1;
        repeat (3) tick();
        idle_ctl();
        tests++;
        if (RUN !== 1'b0 || {W1, W2, W3} !== held || PC !== m_pc) begin
            fails++;
            $display("FAIL stopped_hold: got run=%b beat=%b pc=%h want run=0 beat=%b pc=%h",
                     RUN, {W1, W2, W3}, PC, held, m_pc);
        end
        QD = 0;
        repeat (2) tick();
        QD = 1;
        repeat (2) tick();
        QD = 0;
        tests++;
        if (RUN !== 1'b1 || {W1, W2, W3} !== held) begin
            fails++;
            $display("FAIL restart_resume: got run=%b beat=%b want run=1 beat=%b",
                     RUN, {W1, W2, W3}, held);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [10] = '{4'b1001, 4'b0110, 4'b0000, 4'b1011, 4'b1110,
                                   4'b1111, 4'b1010, 4'b0110, 4'b0011, 4'b1111};
        for (int n = 0; n < 400; n++) begin
            {LDZ, LDC, CIN, DRW, M, ABUS, SBUS, MBUS, PCINC, PCADD, ARINC} = 11'($urandom);
            {LPC, LAR, LIR, MEMW, SELCTL, LONG, SHORT} = 7'($urandom);
            STOP = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) QD = ~QD;
            S = codes[$urandom_range(0, 9)];
            SEL = 4'($urandom);
            SD = 8'($urandom);
            MEM_RDATA = 8'($urandom);
            #1;
            tests++;
            if ({DBUS, MEM_WDATA, MEM_ADDR, MEM_WE} !==
                {m_dbus(), m_dbus(), LIR ? m_pc : m_ar, MEMW & m_run}) begin
                fails++;
                $display("FAIL rand_comb[%0d]: got dbus=%h wd=%h addr=%h we=%b want dbus=%h addr=%h we=%b",
                         n, DBUS, MEM_WDATA, MEM_ADDR, MEM_WE, m_dbus(), LIR ? m_pc : m_ar, MEMW & m_run);
            end
            tick();
            tests++;
            if ({PC, AR, IR, C, Z, RUN, W1, W2, W3} !==
                {m_pc, m_ar, m_ir[7:4], m_c, m_z, m_run, m_beat == 1, m_beat == 2, m_beat == 3}) begin
                fails++;
                $display("FAIL rand_state[%0d]: got pc=%h ar=%h ir=%h c=%b z=%b run=%b beat=%b%b%b want pc=%h ar=%h ir=%h c=%b z=%b run=%b beat=%0d",
                         n, PC, AR, IR, C, Z, RUN, W1, W2, W3, m_pc, m_ar, m_ir[7:4], m_c, m_z, m_run, m_beat);
            end
        end
        idle_ctl();
    endtask

    initial begin
        idle_ctl();
        model_reset();
        CLR = 1'b0;
        #12;
        @(negedge CLK);
        CLR = 1'b1;
        tick();
        test_reset();
        test_beats();
        test_alu_flags();
        test_pc();
        test_mem();
        test_stop_qd();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
